// File: rtl/maria_dma_pkg.sv
// Shared types and constants for the MARIA DMA controller.
package maria_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT_REQ,
    WAIT_REL,
    ADDR,
    DATA,
    RELEASE
  } dma_state_e;

  // Every byte is one ADDR tick followed by one DATA tick.
  localparam int unsigned BYTE_TICKS            = 2;
  localparam int unsigned TIMEOUT_TICKS_DEFAULT = 255;

endpackage

// File: rtl/maria_dma_ctrl_if.sv
// Request, CPU-handshake and bus signals of the MARIA DMA controller.
interface maria_dma_ctrl_if;

  logic        dma_req;
  logic [15:0] dma_addr;
  logic [7:0]  dma_len;
  logic        cpu_released;
  logic [7:0]  db_in;
  logic        halt_n;
  logic        drive_AB;
  logic [15:0] ab_out;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        busy;
  logic        done;
  logic        timeout_err;

  modport master (
    input  dma_req, dma_addr, dma_len, cpu_released, db_in,
    output halt_n, drive_AB, ab_out, data_out, data_valid, busy, done, timeout_err
  );

  modport slave (
    output dma_req, dma_addr, dma_len, cpu_released, db_in,
    input  halt_n, drive_AB, ab_out, data_out, data_valid, busy, done, timeout_err
  );

endinterface

// File: rtl/maria_dma_ctrl.sv
// MARIA DMA controller: halts the CPU, reads dma_len bytes from db_in, then releases the bus.
// Build option: define MARIA_DMA_TIMEOUT_EN to abort when the CPU never releases the bus.
module maria_dma_ctrl
  import maria_dma_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEFAULT
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             mclk1,
  maria_dma_ctrl_if.master bus
);

  dma_state_e  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;

`ifdef MARIA_DMA_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_TICKS);
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       timeout_err_q, timeout_err_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |8'(TIMEOUT_TICKS);
`endif

  // NOTE: every next-state value is given a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    data_d  = data_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
`ifdef MARIA_DMA_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    if (mclk1) begin
      case (state_q)
        IDLE: begin
          if (bus.dma_req) begin
            if (bus.dma_len == 8'd0) begin
              done_d = 1'b1;
            end else begin
              addr_d  = bus.dma_addr;
              len_d   = bus.dma_len;
              state_d = HALT_REQ;
`ifdef MARIA_DMA_TIMEOUT_EN
              timeout_err_d = 1'b0;
`endif
            end
          end
        end
        HALT_REQ: begin
          state_d = WAIT_REL;
`ifdef MARIA_DMA_TIMEOUT_EN
          tmo_cnt_d = 8'd0;
`endif
        end
        WAIT_REL: begin
`ifdef MARIA_DMA_TIMEOUT_EN
          tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
          if (bus.cpu_released) begin
            state_d = ADDR;
          end
`ifdef MARIA_DMA_TIMEOUT_EN
          else if (tmo_cnt_d == TIMEOUT_LIMIT) begin
            state_d       = RELEASE;
            timeout_err_d = 1'b1;
            done_d        = 1'b1;
          end
`endif
        end
        ADDR: state_d = DATA;
        DATA: begin
          data_d  = bus.db_in;
          valid_d = 1'b1;
          addr_d  = addr_q + 16'd1;
          len_d   = len_q - 8'd1;
          // done is registered here so it is visible during the RELEASE state.
          if (len_q == 8'd1) begin
            state_d = RELEASE;
            done_d  = 1'b1;
          end else begin
            state_d = ADDR;
          end
        end
        RELEASE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 16'd0;
      len_q   <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

`ifdef MARIA_DMA_TIMEOUT_EN
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      tmo_cnt_q     <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  // Bus ownership decodes straight from the state register, so reset frees the bus at once.
  assign bus.halt_n     = !(state_q inside {HALT_REQ, WAIT_REL, ADDR, DATA});
  assign bus.drive_AB   = state_q inside {ADDR, DATA};
  assign bus.ab_out     = addr_q;
  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;

endmodule

// File: doc/maria_dma_ctrl.md
MARIA_DMA_CTRL -- requirements
Module: maria_dma_ctrl

Interface
REQ-001 Parameter TIMEOUT_TICKS, default 255, is the number of mclk1 ticks to wait for CPU release before aborting; legal range 1..255.
REQ-002 clk_sys  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 mclk1  in  1  MARIA clock enable; all state advances only when mclk1=1.
REQ-005 dma_req  in  1  one-cycle start strobe, sampled only when mclk1=1.
REQ-006 dma_addr  in  16  start address, captured with dma_req.
REQ-007 dma_len  in  8  byte count, captured with dma_req; 0 is legal.
REQ-008 cpu_released  in  1  the CPU has released the bus.
REQ-009 db_in  in  8  read data bus.
REQ-010 halt_n  out  1  active-low halt request to the CPU.
REQ-011 drive_AB  out  1  this block owns the address bus.
REQ-012 ab_out  out  16  DMA address.
REQ-013 data_out  out  8  captured byte.
REQ-014 data_valid  out  1  one-clk_sys pulse: data_out holds a new byte.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-clk_sys pulse at the end of a transfer or an abort.
REQ-017 timeout_err  out  1  sticky flag: the last transfer aborted on timeout.

Function
REQ-018 States: IDLE, HALT_REQ, WAIT_REL, ADDR, DATA, RELEASE; each transition SHALL occur on a clk_sys edge with mclk1=1.
REQ-019 IDLE: when dma_req=1 and dma_len!=0, capture addr/len, clear timeout_err and go to HALT_REQ.
REQ-020 IDLE: when dma_req=1 and dma_len=0, pulse done and stay in IDLE; halt_n SHALL NOT drop.
REQ-021 HALT_REQ: halt_n=0; go to WAIT_REL on the next tick.
REQ-022 WAIT_REL: keep halt_n=0; go to ADDR when cpu_released=1; the timeout counter SHALL increment each tick.
REQ-023 If the timeout counter reaches TIMEOUT_TICKS in WAIT_REL, go to RELEASE, set timeout_err, and issue no bus cycles.
REQ-024 ADDR: drive_AB=1 and ab_out=current address; go to DATA.
REQ-025 DATA: drive_AB=1; latch db_in into data_out; pulse data_valid; increment the address modulo 2^16 (FFFF wraps to 0000); decrement the count.
REQ-026 After DATA: if count=0 go to RELEASE, else go to ADDR; each byte SHALL take exactly 2 mclk1 ticks.
REQ-027 RELEASE: drive_AB=0, halt_n=1, pulse done, go to IDLE.
REQ-028 dma_req received while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-029 If cpu_released drops during ADDR/DATA, the transfer continues unchanged.
REQ-030 drive_AB SHALL be 1 only in ADDR and DATA.

Reset
REQ-031 While rst=1: state=IDLE, halt_n=1, drive_AB=0, ab_out=0, data_out=0, data_valid=0, done=0, busy=0, timeout_err=0, counters=0.
REQ-032 rst takes priority over mclk1.
REQ-033 Assertion of rst mid-transfer SHALL release the bus in the same cycle and SHALL NOT pulse done.

Configuration
REQ-034 Macro MARIA_DMA_TIMEOUT_EN:
- Defined: REQ-022/REQ-023 timeout logic present.
- Undefined: WAIT_REL waits indefinitely; no timeout counter; timeout_err is tied to 0.

Structure
REQ-035 Package maria_dma_pkg SHALL hold:
- the state enum;
- the BYTE_TICKS=2 constant;
- the default TIMEOUT_TICKS constant.
REQ-036 The block SHALL be one module with no sub-modules; the timeout counter is inline.

Verification
REQ-037 addr=1000, len=3, cpu_released 2 ticks after halt_n falls:
- ab_out 1000,1001,1002;
- 3 data_valid pulses;
- done one tick after the last DATA;
- halt_n=1 at done.
REQ-038 addr=FFFF, len=2: ab_out FFFF then 0000.
REQ-039 len=0: done one cycle after dma_req; halt_n stays 1; busy stays 0.
REQ-040 MARIA_DMA_TIMEOUT_EN defined, TIMEOUT_TICKS=4, cpu_released held 0:
- RELEASE after 4 WAIT_REL ticks;
- timeout_err=1, done pulses;
- drive_AB never 1.
REQ-041 rst asserted during DATA of byte 2 of 4: next cycle halt_n=1, drive_AB=0, busy=0, no done pulse.
REQ-042 Second dma_req during a transfer: ignored; exactly len bytes delivered; one done pulse.
